slc3_stim_sequencer: RTL and testbench
======================================

// Module: slc3_stim_sequencer
// PURPOSE
//  Synthesizable Run/Continue stimulus generator for the SLC-3 top level.
//  Replaces hand-written push-button vectors with a parametrised sequence:
//  - one Run press
//  - then a runtime-selected number of Continue presses
//  - fixed press and gap widths between presses
//  Outputs are active-low, button-style, and wire straight to the CPU's Run/Continue inputs.
//  Supports on-board self-test and simulation.
// PARAMETERS
//  PRESS_CYC  1   cycles each button is held low (>=1)
//  GAP_CYC    3   cycles buttons are high after each press (>=1)
//  CNT_W      8   width of Count and PressCnt
// PORTS
//  Clk       in   1      system clock, all logic on rising edge
//  Reset     in   1      synchronous reset, active-low
//  Start     in   1      begin a sequence; sampled only in IDLE
//  Abort     in   1      synchronous abort, active-high
//  Count     in   CNT_W  number of Continue presses; sampled with Start
//  Run       out  1      Run button, active-low
//  Continue  out  1      Continue button, active-low
//  Busy      out  1      high while a sequence is in progress
//  Done      out  1      one-cycle pulse when a sequence completes normally
//  PressCnt  out  CNT_W  Continue presses completed in the current/last sequence
// BEHAVIOUR
//  Outputs and registers
//  - All outputs registered.
//  - Reset (Reset==0 at edge) -> state IDLE, Run=1, Continue=1, Busy=0, Done=0, PressCnt=0, timers=0.
//  - Reset has priority over Abort and Start.
//  States: IDLE, RUN_PRS, RUN_GAP, CON_PRS, CON_GAP, DONE.
//  IDLE
//  - Start==1 at edge k: latch Count into cnt_q, clear PressCnt, go RUN_PRS.
//  - Run=0 and Busy=1 from cycle k+1 (latency 1).
//  Press/gap timing
//  - RUN_PRS: Run=0 for exactly PRESS_CYC cycles -> RUN_GAP.
//  - RUN_GAP: both high for GAP_CYC cycles.
//    - At end: cnt_q==0 -> DONE; else -> CON_PRS.
//  - CON_PRS: Continue=0 for exactly PRESS_CYC cycles.
//    - On exit: PressCnt += 1, go CON_GAP.
//  - CON_GAP: both high for GAP_CYC cycles.
//    - At end: PressCnt==cnt_q -> DONE; else -> CON_PRS.
//  DONE
//  - Lasts one cycle: Done=1, Busy=0, then IDLE.
//  - PressCnt holds until the next accepted Start.
//  Invariants and edge cases
//  - Run and Continue are never low in the same cycle.
//  - Busy=1 in every state except IDLE and DONE.
//  - Start while not IDLE (including DONE) is ignored; Count changes mid-sequence are ignored.
//  - Abort==1 in any non-IDLE state:
//    - next cycle IDLE, Run=1, Continue=1, Busy=0, no Done pulse.
//    - PressCnt keeps its value at abort.
//  - Abort and Start together in IDLE: Abort wins, stay IDLE.
//  - Timers: one down-counter of width $clog2(max(PRESS_CYC,GAP_CYC)+1), reloaded on each state entry.
//  - Count at max (2^CNT_W-1) must complete without wrap.
//  - Sequence length, accepted Start to Done: (Count+1)*(PRESS_CYC+GAP_CYC)+1 cycles.
// TESTING (default parameters)
//  1. Reset=0 for 2 cycles then 1 -> Run=1, Continue=1, Busy=0, Done=0, PressCnt=0.
//  2. Count=5, Start 1 cycle:
//     - Run low 1 cycle, gap 3, then 5 Continue pulses 1 low/3 high.
//     - Done pulses at cycle 25 after Start; PressCnt=5.
//  3. Count=0, Start -> single Run pulse; Done 5 cycles after Start; Continue never low; PressCnt=0.
//  4. Count=3, Abort during 2nd Continue press:
//     - Continue=1 and Busy=0 next cycle, Done stays 0, PressCnt=1.
//  5. Count=2, Start re-asserted during RUN_GAP and in DONE cycle:
//     - ignored; exactly 2 Continue presses; one Done.
//  6. Reset=0 mid CON_PRS -> next cycle all outputs at reset values; bench asserts Run&Continue never both 0.

Source files
------------

// File: rtl/slc3_stim_sequencer.sv
// Run/Continue push-button stimulus generator for the SLC-3 top level.
// Issues one Run press followed by a programmable number of Continue
// presses, each press PRESS_CYC cycles low and followed by GAP_CYC cycles
// high. Button outputs are active-low and registered.
module slc3_stim_sequencer #(
  parameter int PRESS_CYC = 1,
  parameter int GAP_CYC   = 3,
  parameter int CNT_W     = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic [CNT_W-1:0] Count,
  output logic             Run,
  output logic             Continue,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] PressCnt
);

  localparam int MAXC = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] PRESS_LD = TW'(PRESS_CYC - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN_PRS,
    RUN_GAP,
    CON_PRS,
    CON_GAP,
    DONE
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] cnt_q;

  // Sequencer: outputs are assigned alongside each transition so they
  // reflect the state being entered, giving one cycle of latency from Start.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      Run      <= 1'b1;
      Continue <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      PressCnt <= '0;
      timer    <= '0;
      cnt_q    <= '0;
    end else begin
      Done <= 1'b0;
      if (state == IDLE) begin
        if (Start && !Abort) begin
          cnt_q    <= Count;
          PressCnt <= '0;
          state    <= RUN_PRS;
          timer    <= PRESS_LD;
          Run      <= 1'b0;
          Busy     <= 1'b1;
        end
      end else if (Abort) begin
        state    <= IDLE;
        Run      <= 1'b1;
        Continue <= 1'b1;
        Busy     <= 1'b0;
        timer    <= '0;
      end else begin
        case (state)
          RUN_PRS: begin
            if (timer == '0) begin
              state <= RUN_GAP;
              timer <= GAP_LD;
              Run   <= 1'b1;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          RUN_GAP: begin
            if (timer == '0) begin
              if (cnt_q == '0) begin
                state <= DONE;
                Busy  <= 1'b0;
                Done  <= 1'b1;
              end else begin
                state    <= CON_PRS;
                timer    <= PRESS_LD;
                Continue <= 1'b0;
              end
            end else begin
              timer <= timer - TW'(1);
            end
          end
          CON_PRS: begin
            if (timer == '0) begin
              state    <= CON_GAP;
              timer    <= GAP_LD;
              Continue <= 1'b1;
              PressCnt <= PressCnt + CNT_W'(1);
            end else begin
              timer <= timer - TW'(1);
            end
          end
          CON_GAP: begin
            if (timer == '0) begin
              if (PressCnt == cnt_q) begin
                state <= DONE;
                Busy  <= 1'b0;
                Done  <= 1'b1;
              end else begin
                state    <= CON_PRS;
                timer    <= PRESS_LD;
                Continue <= 1'b0;
              end
            end else begin
              timer <= timer - TW'(1);
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state    <= IDLE;
            Run      <= 1'b1;
            Continue <= 1'b1;
            Busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slc3_stim_sequencer.sv
// Self-checking bench for slc3_stim_sequencer with randomized stimulus
// compared against a cycle-index reference model of the press schedule.
module tb_slc3_stim_sequencer;

  localparam int P = 1;
  localparam int G = 3;
  localparam int W = 8;
  localparam int OW = W + 4;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic         Abort;
  logic [W-1:0] Count;
  logic         Run;
  logic         Continue;
  logic         Busy;
  logic         Done;
  logic [W-1:0] PressCnt;

  int errors = 0;
  int checks = 0;

  slc3_stim_sequencer #(
    .PRESS_CYC(P),
    .GAP_CYC  (G),
    .CNT_W    (W)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Abort   (Abort),
    .Count   (Count),
    .Run     (Run),
    .Continue(Continue),
    .Busy    (Busy),
    .Done    (Done),
    .PressCnt(PressCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Run and Continue must never both be low.
  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      checks++;
      if (Run === 1'b0 && Continue === 1'b0) begin
        errors++;
        $display("FAIL both_low at %0t: Run=%b Continue=%b required not both 0", $time, Run, Continue);
      end
    end
  end

  // Expected {Run,Continue,Busy,Done,PressCnt} at cycle t after an accepted
  // Start (t=1 is the first cycle with registered outputs), with no abort.
  function automatic logic [OW-1:0] model(input int unsigned cnt, input int unsigned t);
    int unsigned per, len, seg, pos, pc;
    logic        low, r, c, b, d;
    per = P + G;
    len = (cnt + 1) * per;
    if (t >= 1 && t <= len) begin
      seg = (t - 1) / per;
      pos = (t - 1) % per;
      low = (pos < P);
      r   = !(low && seg == 0);
      c   = !(low && seg > 0);
      b   = 1'b1;
      d   = 1'b0;
      if (seg == 0)  pc = 0;
      else if (low)  pc = seg - 1;
      else           pc = seg;
    end else if (t == len + 1) begin
      r = 1'b1; c = 1'b1; b = 1'b0; d = 1'b1; pc = cnt;
    end else begin
      r = 1'b1; c = 1'b1; b = 1'b0; d = 1'b0; pc = cnt;
    end
    return {r, c, b, d, W'(pc)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Starts one sequence; abort_t>0 asserts Abort during that cycle.
  // noise enables random Start/Count toggling wherever Start must be ignored.
  task automatic run_seq(input int unsigned cnt, input int unsigned abort_t,
                         input bit noise, input string tag, output int unsigned ndone);
    int unsigned     len;
    logic [OW-1:0]   exp_v, got_v, held;
    logic [W-1:0]    held_pc;
    len     = (cnt + 1) * (P + G);
    ndone   = 0;
    held_pc = '0;
    Count   = W'(cnt);
    Start   = 1'b1;
    Abort   = 1'b0;
    tick();
    Start = 1'b0;
    for (int unsigned t = 1; t <= len + 3; t++) begin
      if (abort_t != 0 && t > abort_t) exp_v = {1'b1, 1'b1, 1'b0, 1'b0, held_pc};
      else exp_v = model(cnt, t);
      got_v = {Run, Continue, Busy, Done, PressCnt};
      held  = exp_v;
      held_pc = held[W-1:0];
      if (Done === 1'b1) ndone++;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s cnt=%0d t=%0d got {Run,Cont,Busy,Done,PressCnt}=%b required %b",
                 tag, cnt, t, got_v, exp_v);
      end
      Abort = (abort_t != 0 && t == abort_t);
      Count = W'($urandom);
      if (noise && t <= len + 1 && (abort_t == 0 || t <= abort_t)) Start = 1'($urandom);
      else Start = 1'b0;
      tick();
    end
    Start = 1'b0;
    Abort = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0; Count = '0;
    tick();
    tick();
    Reset = 1'b1;
    checks++;
    if ({Run, Continue, Busy, Done, PressCnt} !== {1'b1, 1'b1, 1'b0, 1'b0, W'(0)}) begin
      errors++;
      $display("FAIL reset got %b%b%b%b pc=%0d required 1100 pc=0", Run, Continue, Busy, Done, PressCnt);
    end
    tick();
  endtask

  task automatic test_count5();
    int unsigned nd;
    run_seq(5, 0, 1'b0, "count5", nd);
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL count5_done got %0d required 1", nd); end
  endtask

  task automatic test_count0();
    int unsigned nd;
    run_seq(0, 0, 1'b0, "count0", nd);
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL count0_done got %0d required 1", nd); end
  endtask

  task automatic test_abort();
    int unsigned nd;
    // second Continue press with Count=3 is cycle 9
    run_seq(3, 9, 1'b0, "abort_2nd_press", nd);
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL abort_done got %0d required 0", nd); end
    for (int i = 0; i < 4; i++) begin
      int unsigned c, len, at;
      c   = $urandom_range(0, 6);
      len = (c + 1) * (P + G);
      at  = $urandom_range(1, len);
      run_seq(c, at, 1'b1, "abort_rand", nd);
    end
  endtask

  task automatic test_abort_start_idle();
    Start = 1'b1; Abort = 1'b1; Count = 8'd4;
    tick();
    Start = 1'b0; Abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({Run, Continue, Busy} !== 3'b110) begin
        errors++;
        $display("FAIL abort_start_idle got Run,Cont,Busy=%b%b%b required 110", Run, Continue, Busy);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int unsigned nd, len;
    len   = 3 * (P + G);
    Count = 8'd2;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    nd    = 0;
    for (int unsigned t = 1; t <= len + 3; t++) begin
      logic [OW-1:0] e;
      e = model(2, t);
      if (Done === 1'b1) nd++;
      checks++;
      if ({Run, Continue, Busy, Done, PressCnt} !== e) begin
        errors++;
        $display("FAIL restart t=%0d got %b required %b", t, {Run, Continue, Busy, Done, PressCnt}, e);
      end
      // t=2 is in RUN_GAP, t=len+1 is the DONE cycle
      Start = (t == 2 || t == len + 1);
      Count = 8'd7;
      tick();
    end
    Start = 1'b0;
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL restart_done got %0d required 1", nd); end
  endtask

  task automatic test_back_to_back();
    int unsigned nd;
    for (int i = 0; i < 5; i++) run_seq($urandom_range(0, 12), 0, 1'b1, "rand", nd);
    run_seq(255, 0, 1'b0, "count_max", nd);
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL count_max_done got %0d required 1", nd); end
  endtask

  task automatic test_reset_mid();
    Count = 8'd3;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    // cycle 5 is the first Continue press
    for (int t = 1; t < 5; t++) tick();
    checks++;
    if (Continue !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pre got Continue=%b required 0", Continue);
    end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    checks++;
    if ({Run, Continue, Busy, Done, PressCnt} !== {1'b1, 1'b1, 1'b0, 1'b0, W'(0)}) begin
      errors++;
      $display("FAIL reset_mid got %b%b%b%b pc=%0d required 1100 pc=0", Run, Continue, Busy, Done, PressCnt);
    end
    tick();
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0; Count = '0;
    test_reset();
    test_count5();
    test_count0();
    test_abort();
    test_abort_start_idle();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
